instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the RV32IM five-stage pipeline. It holds the program counter, drives the word address into the combinational instruction memory, and latches the returned instruction into the IF/ID pipeline register. It also handles load-use stalls, branch/jump redirects from EX, and alignment and range faults. It sits directly upstream of the instruction memory and feeds the decode stage.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- MEM_WORDS, 1024: instruction memory depth in 32-bit words; fetches at or beyond this depth fault.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- stall, input, 1: hazard unit hold request for PC and IF/ID.
- branch_taken, input, 1: redirect request from EX.
- branch_target, input, 32: byte address of the redirect.
- imem_addr, output, 32: word index to instruction memory, {2'b00, pc[31:2]}. Combinational from the PC register.
- imem_instr, input, 32: instruction returned by memory in the same cycle.
- ifid_pc, output, 32: PC of the latched instruction.
- ifid_pc_plus4, output, 32: ifid_pc + 4, with modulo-2^32 wrap.
- ifid_instr, output, 32: latched instruction, or bubble.
- ifid_valid, output, 1: IF/ID holds a real instruction.
- fetch_fault, output, 1: sticky fault flag.
- fetch_count, output, 32: number of valid instructions latched into IF/ID. Wraps at 2^32.

## Operation

- State machine with two states:
  - RUN: normal fetching.
  - FAULT: PC frozen, IF/ID holds the bubble, and fetch_fault = 1. FAULT exits only through reset.
- Bubble encoding: NOP_INSTR = 32'h0000_0013 (addi x0,x0,0), with ifid_valid = 0.
- Per-edge priority, highest first:
  1. reset: pc <= RESET_PC; IF/ID <= {pc 0, pc+4 0, bubble, valid 0}; fetch_count <= 0; state <= RUN.
  2. State FAULT: hold all registers.
  3. branch_taken with branch_target[1:0] != 0: go to FAULT; IF/ID <= bubble.
  4. branch_taken with an aligned target: pc <= branch_target; IF/ID <= bubble, which squashes the wrong-path fetch. This applies even if stall = 1.
  5. stall: pc and IF/ID hold; fetch_count holds.
  6. pc[31:2] >= MEM_WORDS: go to FAULT; IF/ID <= bubble; the out-of-range word is never latched.
  7. Normal: IF/ID <= {pc, pc+4, imem_instr, 1}; pc <= pc + 4; fetch_count += 1.
- PC arithmetic is 32-bit unsigned; pc + 4 wraps from 32'hFFFF_FFFC to 0. Wrap-around is reached only when MEM_WORDS covers the full space, which it does not at the defaults.
- RESET_PC must be word-aligned. Bits [1:0] of the PC are always 0 in RUN.

## Timing

- Instruction memory is combinational. imem_addr is valid during the cycle after each PC update, and imem_instr is sampled on the next edge.
- Latency: a PC value appears in ifid_pc one edge after it becomes current, given no stall and no redirect.
- Redirect: branch_taken sampled at edge N → the bubble is in IF/ID after N, and the target instruction is in IF/ID after N+1 (one-cycle penalty).
- A stall held for k cycles freezes IF/ID and the PC for exactly k edges, with no duplicate or lost fetch.
- Reset asserted mid-stall or mid-redirect overrides both. Outputs take their reset values after the first edge with reset = 1.
- fetch_fault rises on the edge that enters FAULT.

## Structure

- Shared package rv32_pkg holds NOP_INSTR, the fetch state enum {FETCH_RUN, FETCH_FAULT}, and XLEN = 32.
- One sub-module: if_id_register. It takes inputs load, bubble, and the reset value, and holds pc, pc_plus4, instr and valid. The stage top owns the PC, the FSM, the counter and the fault logic.

## Test plan

- Reset then free-run over memory words 0..3 = A, B, C, D: IF/ID shows (0, A), (4, B), (8, C), (12, D) on consecutive edges; fetch_count = 4.
- Stall asserted for 3 cycles while IF/ID holds PC 8: ifid_pc stays 8 and imem_addr stays 3; the fetch at PC 12 resumes afterwards; fetch_count increments only when not stalled.
- branch_taken = 1 with target 32'h40, together with stall = 1: the bubble is latched (valid 0, instr 32'h13), then ifid_pc = 32'h40. The redirect overrides the stall.
- Branch target 32'h42: fetch_fault = 1 after the edge; the PC stays frozen for 10 further cycles and IF/ID stays a bubble; reset clears the fault and the PC returns to 0.
- Run with MEM_WORDS = 4: on reaching PC 16 the stage faults; the word at index 4 is never latched; fetch_count = 4.
- Reset asserted mid-run at PC 32'h1C: one edge later pc = 0, ifid_valid = 0 and fetch_count = 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: data width, bubble encoding and fetch FSM states.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: holds pc, pc+4, instruction and valid between fetch and decode.
module if_id_register
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            i_reset,
    input  logic            i_load,
    input  logic            i_bubble,
    input  logic [XLEN-1:0] i_reset_value,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus4,
    input  logic [XLEN-1:0] i_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [XLEN-1:0] o_instr,
    output logic            o_valid
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic [XLEN-1:0] r_instr;
    logic            r_valid;

    // A bubble keeps the stale pc fields; only instr/valid mark it as a non-instruction.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_pc       <= i_reset_value;
            r_pc_plus4 <= i_reset_value;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else if (i_bubble) begin
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc_plus4;
            r_instr    <= i_instr;
            r_valid    <= 1'b1;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_instr    = r_instr;
    assign o_valid    = r_valid;

endmodule

// File: rtl/instruction_fetch_stage.sv
// RV32IM fetch stage: PC register, redirect/stall/fault control and the fetch counter.
module instruction_fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] MEM_LIMIT = MEM_WORDS;

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_fetch_count;

    fetch_state_e    w_next_state;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_load;
    logic            w_bubble;
    logic            w_count_inc;
    logic            w_out_of_range;

    assign imem_addr      = {2'b00, r_pc[31:2]};
    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_out_of_range = imem_addr >= MEM_LIMIT;

    // Priority: redirect (misaligned faults) over stall over range fault over normal fetch.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        w_count_inc  = 1'b0;
        unique case (r_state)
            FETCH_RUN: begin
                if (branch_taken) begin
                    w_bubble = 1'b1;
                    if (branch_target[1:0] != 2'b00) begin
                        w_next_state = FETCH_FAULT;
                    end else begin
                        w_next_pc = branch_target;
                    end
                end else if (stall) begin
                    w_next_pc = r_pc;
                end else if (w_out_of_range) begin
                    w_next_state = FETCH_FAULT;
                    w_bubble     = 1'b1;
                end else begin
                    w_load      = 1'b1;
                    w_next_pc   = w_pc_plus4;
                    w_count_inc = 1'b1;
                end
            end
            FETCH_FAULT: begin
                w_next_state = FETCH_FAULT;
            end
            default: begin
                w_next_state = FETCH_FAULT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FETCH_RUN;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_count_inc) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    if_id_register u_if_id (
        .clk          (clk),
        .i_reset      (reset),
        .i_load       (w_load),
        .i_bubble     (w_bubble),
        .i_reset_value('0),
        .i_pc         (r_pc),
        .i_pc_plus4   (w_pc_plus4),
        .i_instr      (imem_instr),
        .o_pc         (ifid_pc),
        .o_pc_plus4   (ifid_pc_plus4),
        .o_instr      (ifid_instr),
        .o_valid      (ifid_valid)
    );

    assign fetch_fault = (r_state == FETCH_FAULT);
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed stalls, redirects, faults and resets.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] count;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];
    logic [31:0] exp_count = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return 32'hAB00_0000 | idx;
    endfunction

    // main instance, default depth
    logic        reset, stall, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr, imem_instr, ifid_pc, ifid_pc_plus4, ifid_instr, fetch_count;
    logic        ifid_valid, fetch_fault;
    assign imem_instr = mem_word(imem_addr);

    instruction_fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr),
        .ifid_valid(ifid_valid), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    // small instance, four-word memory
    logic        s_reset;
    logic [31:0] s_imem_addr, s_imem_instr, s_ifid_pc, s_ifid_pc_plus4, s_ifid_instr, s_fetch_count;
    logic        s_ifid_valid, s_fetch_fault;
    assign s_imem_instr = mem_word(s_imem_addr);

    instruction_fetch_stage #(.MEM_WORDS(4)) dut_small (
        .clk(clk), .reset(s_reset), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .imem_addr(s_imem_addr), .imem_instr(s_imem_instr),
        .ifid_pc(s_ifid_pc), .ifid_pc_plus4(s_ifid_pc_plus4), .ifid_instr(s_ifid_instr),
        .ifid_valid(s_ifid_valid), .fetch_fault(s_fetch_fault), .fetch_count(s_fetch_count)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_t e;
        exp_count = exp_count + 1;
        e.pc    = pc;
        e.instr = mem_word({2'b00, pc[31:2]});
        e.count = exp_count;
        sb.push_back(e);
    endtask

    // monitor: each newly latched valid instruction pops one expected entry
    logic [31:0] prev_count = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ifid_valid === 1'b1 && fetch_count !== prev_count) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_fetch: got pc %h with nothing expected", ifid_pc);
            end else begin
                e = sb.pop_front();
                check("sb_pc", ifid_pc, e.pc);
                check("sb_pc_plus4", ifid_pc_plus4, e.pc + 32'd4);
                check("sb_instr", ifid_instr, e.instr);
                check("sb_count", fetch_count, e.count);
            end
        end
        prev_count = fetch_count;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        s_reset = 1'b1;
        tick();
        check("rst_valid", {31'b0, ifid_valid}, 32'd0);
        check("rst_instr", ifid_instr, NOP);
        check("rst_pc", ifid_pc, 32'h0);
        check("rst_pc_plus4", ifid_pc_plus4, 32'h0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_fault", {31'b0, fetch_fault}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        tick();

        // free run over words 0..2
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_fetch(32'(i * 4));
            tick();
        end
        check("run_imem_addr", imem_addr, 32'd3);

        // three-cycle stall with PC 8 in IF/ID
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ifid_pc", ifid_pc, 32'h8);
            check("stall_imem_addr", imem_addr, 32'd3);
            check("stall_count", fetch_count, 32'd3);
            check("stall_valid", {31'b0, ifid_valid}, 32'd1);
        end
        stall = 1'b0;
        expect_fetch(32'hC);
        tick();
        check("resume_count", fetch_count, 32'd4);

        // redirect together with stall: redirect wins, bubble latched
        branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        check("br_valid", {31'b0, ifid_valid}, 32'd0);
        check("br_instr", ifid_instr, NOP);
        check("br_imem_addr", imem_addr, 32'h10);
        check("br_count", fetch_count, 32'd4);
        expect_fetch(32'h40);
        tick();
        expect_fetch(32'h44);
        tick();

        // misaligned redirect enters FAULT
        branch_taken = 1'b1; branch_target = 32'h42;
        tick();
        branch_taken = 1'b0;
        check("mis_fault", {31'b0, fetch_fault}, 32'd1);
        check("mis_valid", {31'b0, ifid_valid}, 32'd0);
        check("mis_instr", ifid_instr, NOP);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                branch_taken = 1'b1; branch_target = 32'h100;
            end else begin
                branch_taken = 1'b0;
            end
            tick();
            check("fault_hold_addr", imem_addr, 32'h12);
            check("fault_hold_valid", {31'b0, ifid_valid}, 32'd0);
            check("fault_hold_flag", {31'b0, fetch_fault}, 32'd1);
        end
        branch_taken = 1'b0;
        check("fault_hold_count", fetch_count, 32'd6);

        // reset clears the fault
        reset = 1'b1;
        tick();
        check("clr_fault", {31'b0, fetch_fault}, 32'd0);
        check("clr_imem_addr", imem_addr, 32'h0);
        check("clr_count", fetch_count, 32'd0);
        exp_count = 0;

        // run to PC 0x1C, then reset under stall and redirect
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            expect_fetch(32'(i * 4));
            tick();
        end
        check("pre_rst_imem_addr", imem_addr, 32'h7);
        reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        tick();
        check("mid_rst_imem_addr", imem_addr, 32'h0);
        check("mid_rst_valid", {31'b0, ifid_valid}, 32'd0);
        check("mid_rst_count", fetch_count, 32'd0);
        stall = 1'b0; branch_taken = 1'b0;
        tick();

        // four-word memory: faults on reaching PC 16
        s_reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("small_count", s_fetch_count, 32'd4);
        check("small_last_pc", s_ifid_pc, 32'hC);
        check("small_last_instr", s_ifid_instr, mem_word(32'd3));
        check("small_no_fault_yet", {31'b0, s_fetch_fault}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("small_fault", {31'b0, s_fetch_fault}, 32'd1);
            check("small_fault_valid", {31'b0, s_ifid_valid}, 32'd0);
            check("small_fault_instr", s_ifid_instr, NOP);
            check("small_fault_count", s_fetch_count, 32'd4);
            check("small_fault_addr", s_imem_addr, 32'd4);
        end

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
